// File: rtl/axi_lite_arbiter.sv
// Round-robin N-to-1 AXI4-Lite arbiter: one read or write in flight, grant held
// from address phase until the owner's response handshake completes.
module axi_lite_arbiter #(
    parameter int NUM_MASTERS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    // upstream masters, per-master fields packed side by side (master i at slice i)
    input  logic [NUM_MASTERS-1:0]     m_arvalid,
    output logic [NUM_MASTERS-1:0]     m_arready,
    input  logic [NUM_MASTERS*32-1:0]  m_araddr,
    input  logic [NUM_MASTERS-1:0]     m_awvalid,
    output logic [NUM_MASTERS-1:0]     m_awready,
    input  logic [NUM_MASTERS*32-1:0]  m_awaddr,
    input  logic [NUM_MASTERS-1:0]     m_wvalid,
    output logic [NUM_MASTERS-1:0]     m_wready,
    input  logic [NUM_MASTERS*32-1:0]  m_wdata,
    input  logic [NUM_MASTERS*4-1:0]   m_wmask,
    output logic [NUM_MASTERS-1:0]     m_rvalid,
    input  logic [NUM_MASTERS-1:0]     m_rready,
    output logic [NUM_MASTERS*32-1:0]  m_rdata,
    output logic [NUM_MASTERS*2-1:0]   m_rresp,
    output logic [NUM_MASTERS-1:0]     m_bvalid,
    input  logic [NUM_MASTERS-1:0]     m_bready,
    output logic [NUM_MASTERS*2-1:0]   m_bresp,
    // downstream port to the crossbar
    output logic                       s_arvalid,
    input  logic                       s_arready,
    output logic [31:0]                s_araddr,
    output logic                       s_awvalid,
    input  logic                       s_awready,
    output logic [31:0]                s_awaddr,
    output logic                       s_wvalid,
    input  logic                       s_wready,
    output logic [31:0]                s_wdata,
    output logic [3:0]                 s_wmask,
    input  logic                       s_rvalid,
    output logic                       s_rready,
    input  logic [31:0]                s_rdata,
    input  logic [1:0]                 s_rresp,
    input  logic                       s_bvalid,
    output logic                       s_bready,
    input  logic [1:0]                 s_bresp
);
    localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, RDATA, WRESP} state_t;

    state_t          state_reg, state_next;
    logic [OW-1:0]   owner_reg, owner_next;
    logic [OW-1:0]   rr_last_reg, rr_last_next;
    logic            w_done_reg, w_done_next;
    logic [OW-1:0]   grant_idx;
    logic [NUM_MASTERS-1:0] req;

    logic [31:0] araddr_arr [NUM_MASTERS];
    logic [31:0] awaddr_arr [NUM_MASTERS];
    logic [31:0] wdata_arr  [NUM_MASTERS];
    logic [3:0]  wmask_arr  [NUM_MASTERS];

    assign req = m_arvalid | m_awvalid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign araddr_arr[gi]         = m_araddr[gi*32 +: 32];
            assign awaddr_arr[gi]         = m_awaddr[gi*32 +: 32];
            assign wdata_arr[gi]          = m_wdata[gi*32 +: 32];
            assign wmask_arr[gi]          = m_wmask[gi*4 +: 4];
            // response payloads go to everyone; only the valids are owner-gated
            assign m_rdata[gi*32 +: 32]   = s_rdata;
            assign m_rresp[gi*2 +: 2]     = s_rresp;
            assign m_bresp[gi*2 +: 2]     = s_bresp;
        end
    endgenerate

    // first requester strictly after rr_last, wrapping at NUM_MASTERS
    always_comb begin : rr_pick
        logic [OW-1:0] cand;
        logic          found;
        cand      = rr_last_reg;
        found     = 1'b0;
        grant_idx = owner_reg;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = (cand == OW'(NUM_MASTERS - 1)) ? '0 : cand + OW'(1);
            if (!found && req[cand]) begin
                grant_idx = cand;
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            owner_reg   <= '0;
            rr_last_reg <= OW'(NUM_MASTERS - 1);
            w_done_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            rr_last_reg <= rr_last_next;
            w_done_reg  <= w_done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        rr_last_next = rr_last_reg;
        w_done_next  = w_done_reg;
        s_arvalid    = 1'b0;
        s_awvalid    = 1'b0;
        s_wvalid     = 1'b0;
        s_rready     = 1'b0;
        s_bready     = 1'b0;
        s_araddr     = '0;
        s_awaddr     = '0;
        s_wdata      = '0;
        s_wmask      = '0;
        m_arready    = '0;
        m_awready    = '0;
        m_wready     = '0;
        m_rvalid     = '0;
        m_bvalid     = '0;

        if (state_reg != IDLE) begin
            s_araddr = araddr_arr[owner_reg];
            s_awaddr = awaddr_arr[owner_reg];
            s_wdata  = wdata_arr[owner_reg];
            s_wmask  = wmask_arr[owner_reg];
        end

        // W may still be owed after AW is accepted, so forwarding spans ADDR and WRESP
        if ((state_reg == ADDR && !m_arvalid[owner_reg] && m_awvalid[owner_reg]) ||
            state_reg == WRESP) begin
            s_wvalid            = m_wvalid[owner_reg] & ~w_done_reg;
            m_wready[owner_reg] = s_wready & ~w_done_reg;
            if (m_wvalid[owner_reg] && s_wready && !w_done_reg)
                w_done_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (|req) begin
                    owner_next  = grant_idx;
                    state_next  = ADDR;
                    w_done_next = 1'b0;
                end
            end
            ADDR: begin
                if (m_arvalid[owner_reg]) begin
                    s_arvalid            = 1'b1;
                    m_arready[owner_reg] = s_arready;
                    if (s_arready)
                        state_next = RDATA;
                end else if (m_awvalid[owner_reg]) begin
                    s_awvalid            = 1'b1;
                    m_awready[owner_reg] = s_awready;
                    if (s_awready)
                        state_next = WRESP;
                end else begin
                    state_next = IDLE;
                end
            end
            RDATA: begin
                s_rready            = m_rready[owner_reg];
                m_rvalid[owner_reg] = s_rvalid;
                if (s_rvalid && m_rready[owner_reg]) begin
                    state_next   = IDLE;
                    rr_last_next = owner_reg;
                end
            end
            WRESP: begin
                // hold off B until the data beat has actually been accepted
                s_bready            = m_bready[owner_reg] & w_done_reg;
                m_bvalid[owner_reg] = s_bvalid & w_done_reg;
                if (s_bvalid && m_bready[owner_reg] && w_done_reg) begin
                    state_next   = IDLE;
                    rr_last_next = owner_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: two masters, bench-driven slave responses.
module tb_axi_lite_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  m_arvalid = '0, m_arready;
    logic [63:0] m_araddr = '0;
    logic [1:0]  m_awvalid = '0, m_awready;
    logic [63:0] m_awaddr = '0;
    logic [1:0]  m_wvalid = '0, m_wready;
    logic [63:0] m_wdata = '0;
    logic [7:0]  m_wmask = '0;
    logic [1:0]  m_rvalid;
    logic [1:0]  m_rready = 2'b11;
    logic [63:0] m_rdata;
    logic [3:0]  m_rresp;
    logic [1:0]  m_bvalid;
    logic [1:0]  m_bready = 2'b11;
    logic [3:0]  m_bresp;
    logic        s_arvalid, s_arready = 1'b0;
    logic [31:0] s_araddr;
    logic        s_awvalid, s_awready = 1'b0;
    logic [31:0] s_awaddr;
    logic        s_wvalid, s_wready = 1'b0;
    logic [31:0] s_wdata;
    logic [3:0]  s_wmask;
    logic        s_rvalid = 1'b0, s_rready;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0;
    logic        s_bvalid = 1'b0, s_bready;
    logic [1:0]  s_bresp = '0;

    int errors = 0;
    int checks = 0;

    axi_lite_arbiter #(.NUM_MASTERS(2)) dut (
        .clk(clk), .reset(reset),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wmask(m_wmask),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // slave accepts AR, returns data next cycle; owner drops arvalid unless keep
    task automatic serve_read(input int idx, input bit keep, input logic [31:0] data,
                              output logic [31:0] addr_seen);
        logic [1:0] oh;
        int n;
        oh = (idx == 0) ? 2'b01 : 2'b10;
        n = 0;
        while (!s_arvalid && n < 16) begin
            tick();
            n++;
        end
        check("ar_seen", 64'(s_arvalid), 64'd1);
        addr_seen = s_araddr;
        s_arready = 1'b1;
        #1;
        check("arready_owner", 64'(m_arready), 64'(oh));
        tick();
        s_arready = 1'b0;
        if (!keep) m_arvalid = m_arvalid & ~oh;
        s_rvalid = 1'b1;
        s_rdata  = data;
        #1;
        check("rvalid_owner", 64'(m_rvalid), 64'(oh));
        check("rdata_owner", 64'((idx == 0) ? m_rdata[31:0] : m_rdata[63:32]), 64'(data));
        tick();
        s_rvalid = 1'b0;
        $display("read  m%0d addr=%h data=%h", idx, addr_seen, data);
    endtask

    // zero-wait slave: AW and W accepted together, B returned next cycle
    task automatic serve_write(input int idx, output logic [31:0] aw_seen,
                               output logic [31:0] wd_seen, output logic [3:0] wm_seen);
        logic [1:0] oh;
        int n;
        oh = (idx == 0) ? 2'b01 : 2'b10;
        n = 0;
        while (!s_awvalid && n < 16) begin
            tick();
            n++;
        end
        check("aw_seen", 64'(s_awvalid), 64'd1);
        check("w_with_aw", 64'(s_wvalid), 64'd1);
        aw_seen = s_awaddr;
        wd_seen = s_wdata;
        wm_seen = s_wmask;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        #1;
        check("awready_owner", 64'(m_awready), 64'(oh));
        check("wready_owner", 64'(m_wready), 64'(oh));
        tick();
        s_awready = 1'b0;
        s_wready  = 1'b0;
        m_awvalid = m_awvalid & ~oh;
        m_wvalid  = m_wvalid & ~oh;
        s_bvalid  = 1'b1;
        #1;
        check("bvalid_owner", 64'(m_bvalid), 64'(oh));
        tick();
        s_bvalid = 1'b0;
        $display("write m%0d addr=%h data=%h mask=%h", idx, aw_seen, wd_seen, wm_seen);
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [3:0]  wm;
        int bcount;

        do_reset();
        check("rst_s_side", 64'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}), 64'd0);
        check("rst_m_side", 64'({m_arready, m_awready, m_wready, m_rvalid, m_bvalid}), 64'd0);

        // single read from IFU, one cycle of arbitration latency
        m_arvalid = 2'b01;
        m_araddr[31:0] = 32'h8000_0000;
        #1;
        check("rd1_idle_no_valid", 64'(s_arvalid), 64'd0);
        tick();
        check("rd1_arvalid_rise", 64'(s_arvalid), 64'd1);
        check("rd1_araddr", 64'(s_araddr), 64'h8000_0000);
        serve_read(0, 1'b0, 32'hDEAD_BEEF, a);
        #1;
        check("rd1_idle_after", 64'({s_arvalid, m_rvalid}), 64'd0);

        // simultaneous read (m0) and write (m1) after reset: m0 first
        do_reset();
        m_arvalid = 2'b01;
        m_araddr[31:0] = 32'h0000_1000;
        m_awvalid = 2'b10;
        m_wvalid  = 2'b10;
        m_awaddr[63:32] = 32'ha000_03f8;
        m_wdata[63:32]  = 32'h0000_0041;
        m_wmask[7:4]    = 4'h1;
        serve_read(0, 1'b0, 32'h1111_1111, a);
        check("sim_first_m0", 64'(a), 64'h0000_1000);
        serve_write(1, a, wd, wm);
        check("sim_awaddr", 64'(a), 64'ha000_03f8);
        check("sim_wdata", 64'(wd), 64'h41);
        check("sim_wmask", 64'(wm), 64'h1);

        // round robin with both masters reading continuously
        do_reset();
        m_araddr  = {32'h0000_0200, 32'h0000_0100};
        m_arvalid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            serve_read(i % 2, 1'b1, 32'hA0 + 32'(i), a);
            check("rr_order", 64'(a), (i % 2 == 1) ? 64'h200 : 64'h100);
        end
        m_arvalid = 2'b00;
        tick();

        // W accepted two cycles before AW; master keeps wvalid high after its beat
        m_awvalid = 2'b01;
        m_wvalid  = 2'b01;
        m_awaddr[31:0] = 32'h0000_0300;
        m_wdata[31:0]  = 32'h0000_0055;
        m_wmask[3:0]   = 4'hf;
        s_wready  = 1'b1;
        s_awready = 1'b0;
        tick();
        check("wfirst_wvalid", 64'(s_wvalid), 64'd1);
        check("wfirst_wready", 64'(m_wready), 64'b01);
        tick();
        check("wfirst_no_dup", 64'({s_wvalid, m_wready}), 64'd0);
        tick();
        check("wfirst_no_dup2", 64'({s_awvalid, s_wvalid}), 64'b10);
        s_awready = 1'b1;
        #1;
        check("wfirst_awready", 64'(m_awready), 64'b01);
        tick();
        s_awready = 1'b0;
        s_wready  = 1'b0;
        m_awvalid = 2'b00;
        m_wvalid  = 2'b00;
        s_bvalid  = 1'b1;
        bcount = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (m_bvalid[0]) bcount++;
            check("wfirst_m1_no_b", 64'(m_bvalid[1]), 64'd0);
            tick();
        end
        s_bvalid = 1'b0;
        check("wfirst_b_once", 64'(bcount), 64'd1);

        // AW accepted before W: B must wait for the data beat
        m_awvalid = 2'b01;
        m_wvalid  = 2'b01;
        m_awaddr[31:0] = 32'h0000_0310;
        s_awready = 1'b1;
        s_wready  = 1'b0;
        tick();
        tick();
        s_awready = 1'b0;
        m_awvalid = 2'b00;
        s_bvalid  = 1'b1;
        #1;
        check("awfirst_b_gated", 64'({m_bvalid, s_bready}), 64'd0);
        check("awfirst_w_pending", 64'(s_wvalid), 64'd1);
        s_wready = 1'b1;
        tick();
        s_wready = 1'b0;
        m_wvalid = 2'b00;
        #1;
        check("awfirst_b_after_w", 64'({m_bvalid, s_bready, s_wvalid}), 64'b0110);
        tick();
        s_bvalid = 1'b0;

        // owner presents AR and AW together: read first, write in a later grant
        m_arvalid = 2'b10;
        m_awvalid = 2'b10;
        m_wvalid  = 2'b10;
        m_araddr[63:32] = 32'h0000_0400;
        m_awaddr[63:32] = 32'h0000_0500;
        m_wdata[63:32]  = 32'h0000_0077;
        m_wmask[7:4]    = 4'h3;
        tick();
        check("both_read_wins", 64'({s_arvalid, s_awvalid, s_wvalid}), 64'b100);
        serve_read(1, 1'b0, 32'h2222_2222, a);
        check("both_read_addr", 64'(a), 64'h400);
        serve_write(1, a, wd, wm);
        check("both_write_addr", 64'(a), 64'h500);
        check("both_write_data", 64'(wd), 64'h77);

        // reset while RDATA has a pending response
        m_arvalid = 2'b01;
        m_araddr[31:0] = 32'h0000_2000;
        m_rready  = 2'b00;
        tick();
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        #1;
        check("rst_mid_rvalid", 64'(m_rvalid), 64'b01);
        reset = 1'b1;
        tick();
        check("rst_mid_s_side", 64'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}), 64'd0);
        check("rst_mid_m_side", 64'({m_arready, m_awready, m_wready, m_rvalid, m_bvalid}), 64'd0);
        m_arvalid = 2'b00;
        s_rvalid  = 1'b0;
        m_rready  = 2'b11;
        reset     = 1'b0;
        m_arvalid = 2'b10;
        m_araddr[63:32] = 32'h0000_0600;
        serve_read(1, 1'b0, 32'hCAFE_0001, a);
        check("rst_mid_new_read", 64'(a), 64'h600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
